// File: rtl/lc3_pkg.sv
// Shared register-file constants and types.
// The write-back arbiter takes its parameter defaults from here.
package lc3_pkg;
  localparam int NREG_C = 8;
  localparam int WORD_W = 16;
  localparam int DR_W   = 3;

  typedef logic [DR_W-1:0]   reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Scans from index ptr upward, wrapping modulo N, and returns a one-hot winner.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic          found
);

  logic [PW-1:0] idx;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        win[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port among NREQ write-back sources.
// It also keeps a pending-write scoreboard that decode uses for RAW stalls.
module regfile_wb_arbiter
  import lc3_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = WORD_W,
  parameter int NREG  = NREG_C
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*$clog2(NREG)-1:0]  req_dr,
  input  logic [NREQ*WIDTH-1:0]         req_data,
  output logic [NREQ-1:0]               gnt,
  output logic                          wr_en,
  output logic [$clog2(NREG)-1:0]       wr_dr,
  output logic [WIDTH-1:0]              wr_data,
  input  logic                          rsv_valid,
  input  logic [$clog2(NREG)-1:0]       rsv_dr,
  input  logic                          flush,
  output logic [NREG-1:0]               pending,
  output logic                          rsv_err
);

  localparam int IDX_W = $clog2(NREG);
  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  win;
  logic             found;
  logic [PTR_W-1:0] win_idx;

  logic [NREQ-1:0]  gnt_d, gnt_q;
  logic             wr_en_d, wr_en_q;
  logic [IDX_W-1:0] wr_dr_d, wr_dr_q;
  logic [WIDTH-1:0] wr_data_d, wr_data_q;
  logic [PTR_W-1:0] ptr_d, ptr_q;
  logic [NREG-1:0]  pending_d, pending_q;
  logic             rsv_err_d, rsv_err_q;

  // A requester sees its grant one cycle late, so mask it out while it is still dropping req.
  assign eligible = req & ~gnt_q;

  rr_arbiter #(.N(NREQ), .PW(PTR_W)) u_rr (
    .req   (eligible),
    .ptr   (ptr_q),
    .win   (win),
    .found (found)
  );

  always_comb begin
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) win_idx = PTR_W'(k);
    end
    gnt_d     = win;
    wr_en_d   = found;
    wr_dr_d   = wr_dr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    if (found) begin
      wr_dr_d   = req_dr[int'(win_idx)*IDX_W +: IDX_W];
      wr_data_d = req_data[int'(win_idx)*WIDTH +: WIDTH];
      ptr_d     = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
    end
  end

  // A reservation landing on the register being written this cycle wins and is not an error.
  always_comb begin
    pending_d = pending_q;
    rsv_err_d = rsv_err_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wr_en_q) pending_d[wr_dr_q] = 1'b0;
      if (rsv_valid) begin
        pending_d[rsv_dr] = 1'b1;
        if (pending_q[rsv_dr] && !(wr_en_q && (wr_dr_q == rsv_dr))) rsv_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_dr_q   <= '0;
      wr_data_q <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_dr_q   <= wr_dr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      rsv_err_q <= rsv_err_d;
    end
  end

  assign gnt     = gnt_q;
  assign wr_en   = wr_en_q;
  assign wr_dr   = wr_dr_q;
  assign wr_data = wr_data_q;
  assign pending = pending_q;
  assign rsv_err = rsv_err_q;

endmodule
